core_apb_master_bridge: RTL

//  Initiator end of the peripheral APB: converts the core-side req/gnt/rvalid data

---
 rtl/apb_bridge_pkg.sv | 17 +
 rtl/core_apb_master_bridge.sv | 104 ++++++++++
 2 files changed

// File: rtl/apb_bridge_pkg.sv
// Shared types and defaults for the core-to-APB3 initiator bridge.
package apb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

    // A zero limit disables the watchdog but the counter still needs one bit.
    function automatic int unsigned timeout_cnt_width(input int unsigned limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/core_apb_master_bridge.sv
// Core req/gnt/rvalid port to APB3 initiator: one outstanding transfer,
// PREADY wait states, PSLVERR passthrough and an ACCESS-phase watchdog.
module core_apb_master_bridge
    import apb_bridge_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_i,
    output logic                      gnt_o,
    input  logic [APB_ADDR_WIDTH-1:0] addr_i,
    input  logic                      we_i,
    input  logic [APB_DATA_WIDTH-1:0] wdata_i,
    output logic                      rvalid_o,
    output logic [APB_DATA_WIDTH-1:0] rdata_o,
    output logic                      err_o,
    output logic [APB_ADDR_WIDTH-1:0] paddr_o,
    output logic [APB_DATA_WIDTH-1:0] pwdata_o,
    output logic                      pwrite_o,
    output logic                      psel_o,
    output logic                      penable_o,
    input  logic [APB_DATA_WIDTH-1:0] prdata_i,
    input  logic                      pready_i,
    input  logic                      pslverr_i
);

    localparam int unsigned CNT_W = timeout_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    apb_state_e       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             timeout_hit;

    // The current stalled cycle is the (cnt_reg+1)-th ACCESS cycle without PREADY.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                         ((32'(cnt_reg) + 32'd1) >= 32'(TIMEOUT_CYCLES));

    assign gnt_o = req_i && (state_reg == IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            paddr_o   <= '0;
            pwdata_o  <= '0;
            pwrite_o  <= 1'b0;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            rvalid_o  <= 1'b0;
            err_o     <= 1'b0;
            rdata_o   <= '0;
        end else begin
            rvalid_o <= 1'b0;
            err_o    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_i) begin
                        paddr_o   <= addr_i;
                        pwrite_o  <= we_i;
                        pwdata_o  <= wdata_i;
                        psel_o    <= 1'b1;
                        state_reg <= SETUP;
                    end
                end
                SETUP: begin
                    penable_o <= 1'b1;
                    cnt_reg   <= '0;
                    state_reg <= ACCESS;
                end
                ACCESS: begin
                    // PREADY takes priority over a watchdog expiry in the same cycle.
                    if (pready_i) begin
                        if (!pwrite_o) begin
                            rdata_o <= prdata_i;
                        end
                        err_o     <= pslverr_i;
                        rvalid_o  <= 1'b1;
                        psel_o    <= 1'b0;
                        penable_o <= 1'b0;
                        state_reg <= IDLE;
                    end else if (timeout_hit) begin
                        err_o     <= 1'b1;
                        rdata_o   <= '0;
                        rvalid_o  <= 1'b1;
                        psel_o    <= 1'b0;
                        penable_o <= 1'b0;
                        state_reg <= IDLE;
                    end else if (cnt_reg != CNT_MAX) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    psel_o    <= 1'b0;
                    penable_o <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
